// File: rtl/seq_code_checker.sv
// seq_code_checker
// Receive-side checker for the code sequence 0->2->5->3->4->0.
// Legal codes are mapped to a position index. The checker locks after LOCK_N
// consecutive correct transitions. While locked it flags and counts sequence
// errors, and it drops lock after UNLOCK_N consecutive errors.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid, in_code code strobe and 4-bit received code
//   idx_valid, idx    pulse plus position index of the last legal code
//   locked            checker is locked to the sequence
//   err               pulse: sequence error while locked
//   err_count         saturating error count since reset
//   wrap              pulse: a locked, matching 0 closed a period
//   period_cnt        saturating wrap count, cleared on lock loss
//                     (present only with SEQ_CHK_PERIOD_CNT_EN)
//
// All outputs are registered, so there is one cycle of latency.
module seq_code_checker #(
  parameter int W        = 8,
  parameter int LOCK_N   = 2,
  parameter int UNLOCK_N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [3:0]   in_code,
  output logic         idx_valid,
  output logic [2:0]   idx,
  output logic         locked,
  output logic         err,
  output logic [W-1:0] err_count,
`ifdef SEQ_CHK_PERIOD_CNT_EN
  output logic [W-1:0] period_cnt,
`endif
  output logic         wrap
);

  typedef enum logic [1:0] {HUNT, ACQ, LOCKD} state_t;

  localparam logic [4:0] LOCK_T   = 5'(LOCK_N);
  localparam logic [4:0] UNLOCK_T = 5'(UNLOCK_N);

  function automatic logic legal(input logic [3:0] c);
    return (c == 4'd0) || (c == 4'd2) || (c == 4'd3) || (c == 4'd4) || (c == 4'd5);
  endfunction

  function automatic logic [2:0] code2idx(input logic [3:0] c);
    case (c)
      4'd2:    return 3'd1;
      4'd5:    return 3'd2;
      4'd3:    return 3'd3;
      4'd4:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] succ(input logic [3:0] c);
    case (c)
      4'd0:    return 4'd2;
      4'd2:    return 4'd5;
      4'd5:    return 4'd3;
      4'd3:    return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  state_t       st, st_n;
  logic [3:0]   exp_code, exp_n;
  logic [3:0]   good_run, good_n;
  logic [3:0]   bad_run, bad_n;
  logic         idx_valid_n, err_n, wrap_n;
  logic [2:0]   idx_n;
  logic [W-1:0] cnt_n;
  logic         is_legal, is_match;
  logic [4:0]   good_inc, bad_inc;

  assign is_legal = legal(in_code);
  // exp_code is always a legal code, so a match implies a legal code.
  assign is_match = (in_code == exp_code);
  assign good_inc = {1'b0, good_run} + 5'd1;
  assign bad_inc  = {1'b0, bad_run} + 5'd1;

  always_comb begin
    st_n        = st;
    exp_n       = exp_code;
    good_n      = good_run;
    bad_n       = bad_run;
    idx_valid_n = 1'b0;
    idx_n       = idx;
    err_n       = 1'b0;
    wrap_n      = 1'b0;
    cnt_n       = err_count;
    if (in_valid) begin
      if (is_legal) begin
        idx_valid_n = 1'b1;
        idx_n       = code2idx(in_code);
      end
      case (st)
        HUNT: begin
          if (is_legal) begin
            st_n   = ACQ;
            exp_n  = succ(in_code);
            good_n = '0;
          end
        end
        ACQ: begin
          if (is_match) begin
            exp_n  = succ(in_code);
            good_n = good_inc[3:0];
            if (good_inc >= LOCK_T) begin
              st_n   = LOCKD;
              good_n = '0;
              bad_n  = '0;
            end
          end else if (is_legal) begin
            exp_n  = succ(in_code);
            good_n = '0;
          end else begin
            st_n   = HUNT;
            good_n = '0;
          end
        end
        LOCKD: begin
          if (is_match) begin
            bad_n  = '0;
            exp_n  = succ(in_code);
            wrap_n = (in_code == 4'd0);
          end else begin
            err_n = 1'b1;
            if (err_count != '1) cnt_n = err_count + W'(1);
            // Resync on a legal code; otherwise keep the flywheel turning.
            exp_n = is_legal ? succ(in_code) : succ(exp_code);
            if (bad_inc >= UNLOCK_T) begin
              st_n  = HUNT;
              bad_n = '0;
            end else begin
              bad_n = bad_inc[3:0];
            end
          end
        end
        default: st_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= HUNT;
      exp_code  <= '0;
      good_run  <= '0;
      bad_run   <= '0;
      idx_valid <= 1'b0;
      idx       <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      wrap      <= 1'b0;
    end else begin
      st        <= st_n;
      exp_code  <= exp_n;
      good_run  <= good_n;
      bad_run   <= bad_n;
      idx_valid <= idx_valid_n;
      idx       <= idx_n;
      locked    <= (st_n == LOCKD);
      err       <= err_n;
      err_count <= cnt_n;
      wrap      <= wrap_n;
    end
  end

`ifdef SEQ_CHK_PERIOD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (st == LOCKD && st_n != LOCKD) begin
      period_cnt <= '0;
    end else if (wrap_n && period_cnt != '1) begin
      period_cnt <= period_cnt + W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_code_checker.sv
module tb_seq_code_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_code = 4'd0;

  logic       iv1, lk1, er1, wr1;
  logic [2:0] ix1;
  logic [7:0] cnt1;
  logic       iv2, lk2, er2, wr2;
  logic [2:0] ix2;
  logic [1:0] cnt2;
`ifdef SEQ_CHK_PERIOD_CNT_EN
  logic [7:0] pc1;
  logic [1:0] pc2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_code_checker #(.W(8), .LOCK_N(2), .UNLOCK_N(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .idx_valid(iv1), .idx(ix1), .locked(lk1), .err(er1), .err_count(cnt1),
`ifdef SEQ_CHK_PERIOD_CNT_EN
    .period_cnt(pc1),
`endif
    .wrap(wr1)
  );

  seq_code_checker #(.W(2), .LOCK_N(2), .UNLOCK_N(15)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .idx_valid(iv2), .idx(ix2), .locked(lk2), .err(er2), .err_count(cnt2),
`ifdef SEQ_CHK_PERIOD_CNT_EN
    .period_cnt(pc2),
`endif
    .wrap(wr2)
  );

  typedef struct {
    logic       r, v;
    logic [3:0] c;
    logic       iv;
    logic [2:0] ix;
    logic       lk, er, wr;
    logic [7:0] cnt, pc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, v, input logic [3:0] c,
                              input logic iv, input logic [2:0] ix,
                              input logic lk, er, wr, input logic [7:0] cnt, pc);
    vec_t t;
    t.r = r; t.v = v; t.c = c; t.iv = iv; t.ix = ix;
    t.lk = lk; t.er = er; t.wr = wr; t.cnt = cnt; t.pc = pc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  // Drive one cycle away from the edge, then settle just after the edge.
  task automatic beat(input logic r, input logic v, input logic [3:0] c);
    @(negedge clk);
    rst = r; in_valid = v; in_code = c;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] lk_codes[6] = '{4'd0, 4'd2, 4'd5, 4'd3, 4'd4, 4'd0};
  logic [2:0] lk_idx[6]   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic       lk_lock[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       lk_wrap[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  // Errors (illegal 1) interleaved with the code the flywheel expects next.
  logic [3:0] sat_codes[10] = '{4'd1, 4'd4, 4'd1, 4'd2, 4'd1, 4'd3, 4'd1, 4'd0, 4'd1, 4'd5};

  initial begin
    //           r  v  c   iv ix lk er wr cnt pc
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // reset state
    tv.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0)); // lock-up
    tv.push_back(mk(0, 1, 2, 1, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 5, 1, 2, 1, 0, 0, 0, 0)); // locked after 5
    tv.push_back(mk(0, 1, 3, 1, 3, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 4, 1, 4, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 1)); // wrap
    tv.push_back(mk(0, 0, 7, 0, 0, 1, 0, 0, 0, 1)); // idle beat
    tv.push_back(mk(0, 1, 2, 1, 1, 1, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 5, 1, 2, 1, 0, 0, 0, 1)); // expect 3
    tv.push_back(mk(0, 1, 1, 0, 2, 1, 1, 0, 1, 1)); // illegal: flywheel
    tv.push_back(mk(0, 1, 4, 1, 4, 1, 0, 0, 1, 1)); // accepted
    tv.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 1, 2));
    tv.push_back(mk(0, 1, 2, 1, 1, 1, 0, 0, 1, 2)); // expect 5
    tv.push_back(mk(0, 1, 3, 1, 3, 1, 1, 0, 2, 2)); // error 1, resync to 4
    tv.push_back(mk(0, 1, 3, 1, 3, 0, 1, 0, 3, 0)); // error 2: unlock
    tv.push_back(mk(0, 1, 4, 1, 4, 0, 0, 0, 3, 0)); // HUNT->ACQ
    tv.push_back(mk(0, 1, 9, 0, 4, 0, 0, 0, 3, 0)); // illegal in ACQ: no err
    tv.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 3, 0)); // HUNT->ACQ
    tv.push_back(mk(0, 1, 3, 1, 3, 0, 0, 0, 3, 0)); // legal mismatch: reload
    tv.push_back(mk(0, 1, 4, 1, 4, 0, 0, 0, 3, 0));
    tv.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 3, 0)); // relock, no wrap from ACQ
    tv.push_back(mk(0, 1, 2, 1, 1, 1, 0, 0, 3, 0));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // rst beats in_valid
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 2, 1, 1, 0, 0, 0, 0, 0)); // 0 under rst was ignored
    tv.push_back(mk(0, 1, 5, 1, 2, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 3, 1, 3, 1, 0, 0, 0, 0));

    beat(1, 0, 0);
    for (int i = 0; i < tv.size(); i++) begin
      beat(tv[i].r, tv[i].v, tv[i].c);
      chk($sformatf("row%0d.idx_valid", i), 32'(iv1), 32'(tv[i].iv));
      chk($sformatf("row%0d.idx", i), 32'(ix1), 32'(tv[i].ix));
      chk($sformatf("row%0d.locked", i), 32'(lk1), 32'(tv[i].lk));
      chk($sformatf("row%0d.err", i), 32'(er1), 32'(tv[i].er));
      chk($sformatf("row%0d.wrap", i), 32'(wr1), 32'(tv[i].wr));
      chk($sformatf("row%0d.err_count", i), 32'(cnt1), 32'(tv[i].cnt));
`ifdef SEQ_CHK_PERIOD_CNT_EN
      chk($sformatf("row%0d.period_cnt", i), 32'(pc1), 32'(tv[i].pc));
`endif
    end

    // Lock-up stream with 3 idle cycles between codes.
    beat(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      beat(0, 1, lk_codes[i]);
      chk($sformatf("gap%0d.idx_valid", i), 32'(iv1), 32'd1);
      chk($sformatf("gap%0d.idx", i), 32'(ix1), 32'(lk_idx[i]));
      chk($sformatf("gap%0d.locked", i), 32'(lk1), 32'(lk_lock[i]));
      chk($sformatf("gap%0d.wrap", i), 32'(wr1), 32'(lk_wrap[i]));
      chk($sformatf("gap%0d.err", i), 32'(er1), 32'd0);
      for (int g = 0; g < 3; g++) begin
        beat(0, 0, 4'd1);
        chk($sformatf("gap%0d.%0d.pulses", i, g), {29'd0, iv1, er1, wr1}, 32'd0);
        chk($sformatf("gap%0d.%0d.locked", i, g), 32'(lk1), 32'(lk_lock[i]));
        chk($sformatf("gap%0d.%0d.idx", i, g), 32'(ix1), 32'(lk_idx[i]));
      end
    end

    // Saturation on the W=2 instance, non-consecutive errors.
    beat(1, 0, 0);
    beat(0, 1, 4'd0);
    beat(0, 1, 4'd2);
    beat(0, 1, 4'd5);
    chk("sat.locked", {30'd0, lk1, lk2}, 32'd3);
    for (int i = 0; i < 10; i++) begin
      beat(0, 1, sat_codes[i]);
      chk($sformatf("sat%0d.err", i), {30'd0, er1, er2}, (i % 2 == 0) ? 32'd3 : 32'd0);
      chk($sformatf("sat%0d.cnt_w2", i), 32'(cnt2), (i / 2 + 1 > 3) ? 32'd3 : 32'(i / 2 + 1));
      chk($sformatf("sat%0d.cnt_w8", i), 32'(cnt1), 32'(i / 2 + 1));
      chk($sformatf("sat%0d.locked", i), {30'd0, lk1, lk2}, 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_code_checker.md
# seq_code_checker

Receive-side checker for the 5-state custom code sequence 0→2→5→3→4→0 driven by the sequence counter. Samples a 4-bit code stream under a valid strobe, maps each legal code to its position index, acquires lock after consecutive correct transitions, flags and counts sequence errors while locked, and drops lock after repeated errors. Sits at the consuming end of the counter output and feeds status and error logic.

## Interface
- W, 8, width of the saturating error counter err_count
- LOCK_N, 2, consecutive correct transitions needed to lock (1..15)
- UNLOCK_N, 2, consecutive errors while locked that force loss of lock (1..15)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_code is sampled this cycle
- in_code  input  4  received code
- idx_valid  output  1  one-cycle pulse: idx holds the index of a legal sampled code
- idx  output  3  position index of last legal code (0..4)
- locked  output  1  checker is locked to the sequence
- err  output  1  one-cycle pulse: sequence error detected while locked
- err_count  output  W  saturating count of errors since reset
- wrap  output  1  one-cycle pulse: locked and a matching 0 closes a period

## Operation
- Code map: 0→0, 2→1, 5→2, 3→3, 4→4. Every other code (1, 6..15) is illegal.
- succ(): 0→2, 2→5, 5→3, 3→4, 4→0.
- State machine: HUNT, ACQ, LOCKED. Internal registers: expected code, good_run, bad_run.
- HUNT: legal valid code → ACQ, expected=succ(code), good_run=0. Illegal code → remain in HUNT.
- ACQ: valid code == expected → good_run+1 and expected=succ(code). Reaching LOCK_N → LOCKED, bad_run=0. Mismatch with a legal code → remain in ACQ, reload expected=succ(code), good_run=0. Mismatch with an illegal code → HUNT. No err in ACQ.
- LOCKED, match → bad_run=0, expected=succ(code). wrap=1 when the code is 0.
- LOCKED, mismatch → err=1, err_count+1 (saturates at 2^W-1), bad_run+1.
  - Expected resyncs to succ(code) if the code is legal.
  - Otherwise expected advances by succ(expected) (flywheel).
  - bad_run reaching UNLOCK_N → HUNT, locked=0, bad_run=0.
- in_valid low: no state or register change. All pulse outputs are 0.
- idx_valid/idx update on every valid legal code in any state. Illegal codes leave idx unchanged.

## Timing
- All outputs are registered. Response appears the cycle after in_valid is sampled (1-cycle latency).
- Reset values: idx_valid=0, idx=0, locked=0, err=0, err_count=0, wrap=0. State is HUNT, runs are 0, expected is 0.
- rst has priority over in_valid in the same cycle.
- Reset mid-stream discards lock and err_count. Reacquisition needs 1+LOCK_N valid beats.
- locked rises in the cycle after the LOCK_N-th matching beat. It falls in the cycle after the UNLOCK_N-th consecutive error. The err pulse for that error coincides with locked falling.
- Back-to-back valid beats are supported at full rate. Gaps of any length are transparent.

## Configuration
- SEQ_CHK_PERIOD_CNT_EN defined: adds output port period_cnt (output, W bits). It increments with saturation on each wrap pulse, clears on rst, and clears when lock is lost.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Lock-up: rst, then 0,2,5,3,4,0 on consecutive valid cycles (LOCK_N=2). Expected response:
  - locked=1 the cycle after 5 is sampled.
  - idx sequence 0,1,2,3,4,0.
  - wrap pulses once, after the final 0.
  - err never asserts.
- Single error with flywheel: locked, expected 3, send 1 then 4. Expected response:
  - err pulses once; err_count=1.
  - locked stays 1.
  - 4 is accepted as a match; bad_run clears.
  - idx is not updated for 1.
- Unlock (UNLOCK_N=2): locked, expected 5, send 3 then 3. Expected response:
  - Two err pulses; err_count=2.
  - locked=0 coinciding with the second err pulse.
  - State is HUNT.
  - A following 0,2,5 relocks.
- Valid gaps: the lock-up stream with in_valid low for 3 cycles between each code. Expected response:
  - Identical outputs, delayed only by the gaps.
  - No pulses during the gaps.
- Saturation (W=2, UNLOCK_N=15): locked, then 5 non-consecutive errors (a correct code between each). Expected response: err_count is 3 after the third error and stays 3.
- Mid-stream reset: locked with err_count=1, assert rst for one cycle together with in_valid and code 0. Expected response:
  - All outputs return to reset values; rst has priority over in_valid.
  - The sampled code is ignored.
  - With SEQ_CHK_PERIOD_CNT_EN, period_cnt=0.
